// File: rtl/ram_port_arb_if.sv
// Two-client / single-RAM bus bundle for ram_port_arb.
// The slave modport is the arbiter's view; master is the clients-plus-RAM side.
interface ram_port_arb_if;
    logic       a_req;
    logic       a_we;
    logic [7:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_gnt;
    logic       a_rvalid;
    logic [7:0] a_rdata;

    logic       b_req;
    logic       b_we;
    logic [7:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_gnt;
    logic       b_rvalid;
    logic [7:0] b_rdata;

    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_wren;
    logic       ram_rden;
    logic [7:0] ram_q;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  ram_q,
        output a_gnt, a_rvalid, a_rdata,
        output b_gnt, b_rvalid, b_rdata,
        output ram_addr, ram_wdata, ram_wren, ram_rden
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output ram_q,
        input  a_gnt, a_rvalid, a_rdata,
        input  b_gnt, b_rvalid, b_rdata,
        input  ram_addr, ram_wdata, ram_wren, ram_rden
    );
endinterface

// File: rtl/ram_port_arb.sv
// Round-robin arbiter sharing one 256x8 single-port RAM between ports A and B,
// with an in-order read-return tag pipeline matched to the RAM read latency.
module ram_port_arb #(
    parameter int unsigned RD_LAT = 1
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    ram_port_arb_if.slave bus
);
    localparam int unsigned TAG_D = RD_LAT + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             a_req_q;
    logic             b_req_q;
    logic             last_q;      // 1: B was granted most recently
    logic             elig_a;
    logic             elig_b;
    logic             issue;
    logic             issue_we;
    logic             issue_rd;
    logic             issue_port;  // 1: port B
    logic [7:0]       issue_addr;
    logic [7:0]       issue_wdata;
    logic [TAG_D-1:0] tag_vld;
    logic [TAG_D-1:0] tag_port;

    // Next grant: a port needs a sampled request that is still held and no gnt this cycle.
    always_comb begin
        state_d     = IDLE;
        issue_we    = 1'b0;
        issue_addr  = 8'h00;
        issue_wdata = 8'h00;
        elig_a      = a_req_q && bus.a_req && (state_q != GNT_A);
        elig_b      = b_req_q && bus.b_req && (state_q != GNT_B);

        case ({elig_a, elig_b})
            2'b10:   state_d = GNT_A;
            2'b01:   state_d = GNT_B;
            2'b11:   state_d = last_q ? GNT_A : GNT_B;
            default: state_d = IDLE;
        endcase

        case (state_d)
            GNT_A: begin
                issue_we    = bus.a_we;
                issue_addr  = bus.a_addr;
                issue_wdata = bus.a_wdata;
            end
            GNT_B: begin
                issue_we    = bus.b_we;
                issue_addr  = bus.b_addr;
                issue_wdata = bus.b_wdata;
            end
            default: ;
        endcase

        issue      = (state_d != IDLE);
        issue_rd   = issue && !issue_we;
        issue_port = (state_d == GNT_B);
    end

    // State, request sampling and the registered RAM command.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            a_req_q       <= 1'b0;
            b_req_q       <= 1'b0;
            last_q        <= 1'b1;
            bus.a_gnt     <= 1'b0;
            bus.b_gnt     <= 1'b0;
            bus.ram_wren  <= 1'b0;
            bus.ram_rden  <= 1'b0;
            bus.ram_addr  <= 8'h00;
            bus.ram_wdata <= 8'h00;
        end else begin
            state_q      <= state_d;
            a_req_q      <= bus.a_req;
            b_req_q      <= bus.b_req;
            bus.a_gnt    <= (state_d == GNT_A);
            bus.b_gnt    <= (state_d == GNT_B);
            bus.ram_wren <= issue && issue_we;
            bus.ram_rden <= issue_rd;
            if (issue) begin
                bus.ram_addr  <= issue_addr;
                bus.ram_wdata <= issue_wdata;
                last_q        <= issue_port;
            end
        end
    end

    // Read return: the tag leaves the pipe exactly when ram_q holds that read's data.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tag_vld      <= '0;
            tag_port     <= '0;
            bus.a_rvalid <= 1'b0;
            bus.b_rvalid <= 1'b0;
            bus.a_rdata  <= 8'h00;
            bus.b_rdata  <= 8'h00;
        end else begin
            tag_vld      <= {tag_vld[TAG_D-2:0], issue_rd};
            tag_port     <= {tag_port[TAG_D-2:0], issue_port};
            bus.a_rvalid <= tag_vld[TAG_D-1] && !tag_port[TAG_D-1];
            bus.b_rvalid <= tag_vld[TAG_D-1] && tag_port[TAG_D-1];
            if (tag_vld[TAG_D-1]) begin
                if (tag_port[TAG_D-1]) begin
                    bus.b_rdata <= bus.ram_q;
                end else begin
                    bus.a_rdata <= bus.ram_q;
                end
            end
        end
    end
endmodule
